// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path: parity encoding,
// stop-bit codes and the scheduler state encoding.
package uart_pkg;

    typedef enum logic [1:0] {
        PARITY_NONE,
        PARITY_EVEN,
        PARITY_ODD
    } parity_t;

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT_BUSY,
        WAIT_DONE,
        DRAIN
    } sched_state_t;

    localparam logic [1:0] STOP_ONE = 2'd1;
    localparam logic [1:0] STOP_TWO = 2'd2;

endpackage

// File: rtl/uart_tx_sched_if.sv
// Bundle of requester-side and uart_tx-side signals around the scheduler.
// master = scheduler, slave = requesters plus the uart_tx instance.
interface uart_tx_sched_if #(
    parameter int N_REQ = 4
);
    import uart_pkg::*;

    logic [N_REQ-1:0]   req;
    logic [8*N_REQ-1:0] req_data;
    logic [2*N_REQ-1:0] req_stop_bits;
    logic [2*N_REQ-1:0] req_parity;
    logic [N_REQ-1:0]   req_ack;
    logic [N_REQ-1:0]   req_done;

    logic [7:0]         tx_data;
    logic               tx_start;
    logic [1:0]         stop_bits;
    parity_t            parity;
    logic               tx_busy;
    logic               tx_done;

    modport master (
        input  req, req_data, req_stop_bits, req_parity, tx_busy, tx_done,
        output req_ack, req_done, tx_data, tx_start, stop_bits, parity
    );

    modport slave (
        output req, req_data, req_stop_bits, req_parity, tx_busy, tx_done,
        input  req_ack, req_done, tx_data, tx_start, stop_bits, parity
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or above rr_ptr_i,
// wrapping past N_REQ-1 back to 0.
module rr_arbiter #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]         req_i,
    input  logic [$clog2(N_REQ)-1:0] rr_ptr_i,
    output logic [$clog2(N_REQ)-1:0] grant_o,
    output logic                     valid_o
);
    localparam int IW = $clog2(N_REQ);

    always_comb begin
        grant_o = '0;
        valid_o = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            int s;
            s = int'(rr_ptr_i) + k;
            if (s >= N_REQ) s = s - N_REQ;
            if (!valid_o && req_i[IW'(s)]) begin
                valid_o = 1'b1;
                grant_o = IW'(s);
            end
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one uart_tx among N_REQ byte producers:
// grants, latches byte+framing, launches, and tracks the frame to completion.
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int N_REQ         = 4,
    parameter int START_TIMEOUT = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    uart_tx_sched_if.master          bus,
    output logic                     busy,
    output logic [$clog2(N_REQ)-1:0] grant_id,
    output logic                     err_timeout
);
    localparam int IW = $clog2(N_REQ);
    localparam int CW = $clog2(START_TIMEOUT);
    localparam logic [N_REQ-1:0] ONE = {{(N_REQ-1){1'b0}}, 1'b1};

    sched_state_t     state_q;
    logic [IW-1:0]    rr_ptr_q, grant_q, rr_ptr_d;
    logic [7:0]       tx_data_q;
    logic [1:0]       stop_q;
    parity_t          parity_q;
    logic             tx_start_q, err_q, busy_q;
    logic [N_REQ-1:0] ack_q, done_q;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic [IW-1:0]    arb_grant;
    logic             arb_valid;
    logic [7:0]       sel_data;
    logic [1:0]       sel_stop, sel_par;

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .req_i    (bus.req),
        .rr_ptr_i (rr_ptr_q),
        .grant_o  (arb_grant),
        .valid_o  (arb_valid)
    );

    always_comb begin
        sel_data = '0;
        sel_stop = '0;
        sel_par  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (arb_grant == IW'(i)) begin
                sel_data = bus.req_data[8*i +: 8];
                sel_stop = bus.req_stop_bits[2*i +: 2];
                sel_par  = bus.req_parity[2*i +: 2];
            end
        end
    end

    assign cnt_d    = cnt_q + 1'b1;
    assign rr_ptr_d = (grant_q == IW'(N_REQ-1)) ? '0 : grant_q + 1'b1;

    // Pulse outputs default low each cycle; only the state that owns them raises them.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            grant_q    <= '0;
            tx_data_q  <= '0;
            stop_q     <= STOP_ONE;
            parity_q   <= PARITY_NONE;
            tx_start_q <= 1'b0;
            ack_q      <= '0;
            done_q     <= '0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
            cnt_q      <= '0;
        end else begin
            tx_start_q <= 1'b0;
            ack_q      <= '0;
            done_q     <= '0;
            err_q      <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (arb_valid) begin
                        tx_data_q  <= sel_data;
                        stop_q     <= sel_stop;
                        parity_q   <= parity_t'(sel_par);
                        grant_q    <= arb_grant;
                        ack_q      <= ONE << arb_grant;
                        tx_start_q <= 1'b1;
                        busy_q     <= 1'b1;
                        state_q    <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    cnt_q   <= '0;
                    state_q <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (bus.tx_busy) begin
                        state_q <= WAIT_DONE;
                    end else if (cnt_d == CW'(START_TIMEOUT-1)) begin
                        // Launch abandoned: byte already acked, no done pulse.
                        err_q    <= 1'b1;
                        rr_ptr_q <= rr_ptr_d;
                        busy_q   <= 1'b0;
                        state_q  <= IDLE;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                WAIT_DONE: begin
                    if (bus.tx_done) begin
                        done_q   <= ONE << grant_q;
                        rr_ptr_q <= rr_ptr_d;
                        state_q  <= DRAIN;
                    end
                end
                DRAIN: begin
                    // tx_busy stays high through a second stop bit.
                    if (!bus.tx_busy) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.tx_data   = tx_data_q;
    assign bus.tx_start  = tx_start_q;
    assign bus.stop_bits = stop_q;
    assign bus.parity    = parity_q;
    assign bus.req_ack   = ack_q;
    assign bus.req_done  = done_q;
    assign busy          = busy_q;
    assign grant_id      = grant_q;
    assign err_timeout   = err_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: behavioural uart_tx responder, round-robin
// reference model, and one task per scenario.
module tb_uart_tx_sched;
    import uart_pkg::*;

    localparam int N  = 4;
    localparam int TO = 16;

    logic       clk;
    logic       rst_n;
    logic       busy;
    logic [1:0] grant_id;
    logic       err_timeout;

    uart_tx_sched_if #(.N_REQ(N)) bus ();

    uart_tx_sched #(.N_REQ(N), .START_TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .busy        (busy),
        .grant_id    (grant_id),
        .err_timeout (err_timeout)
    );

    int total, bad;
    int exp_ptr;
    int done_cnt[N];
    int err_cnt;
    logic [7:0] dat[N];
    logic [1:0] stp[N];
    logic [1:0] par[N];

    bit m_en;
    int m_start_dly, m_frame_len, m_stop2_len;
    int m_phase, m_cnt;
    bit m_two;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // uart_tx stand-in: acts on the falling edge so the DUT sees it at the next rise.
    initial begin
        bus.tx_busy = 1'b0;
        bus.tx_done = 1'b0;
        m_phase = 0;
        m_cnt   = 0;
        m_two   = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) begin
                m_phase = 0;
                bus.tx_busy = 1'b0;
                bus.tx_done = 1'b0;
            end else begin
                case (m_phase)
                    0: if (bus.tx_start === 1'b1 && m_en) begin
                        m_two   = (bus.stop_bits == STOP_TWO);
                        m_cnt   = m_start_dly;
                        m_phase = 1;
                    end
                    1: begin
                        m_cnt--;
                        if (m_cnt <= 0) begin
                            bus.tx_busy = 1'b1;
                            m_cnt = m_frame_len;
                            m_phase = 2;
                        end
                    end
                    2: begin
                        m_cnt--;
                        if (m_cnt <= 0) begin
                            bus.tx_done = 1'b1;
                            m_phase = 3;
                        end
                    end
                    3: begin
                        bus.tx_done = 1'b0;
                        if (m_two && m_stop2_len > 0) begin
                            m_cnt = m_stop2_len;
                            m_phase = 4;
                        end else begin
                            bus.tx_busy = 1'b0;
                            m_phase = 0;
                        end
                    end
                    4: begin
                        m_cnt--;
                        if (m_cnt <= 0) begin
                            bus.tx_busy = 1'b0;
                            m_phase = 0;
                        end
                    end
                    default: m_phase = 0;
                endcase
            end
        end
    end

    initial begin
        for (int i = 0; i < N; i++) done_cnt[i] = 0;
        err_cnt = 0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < N; i++) if (bus.req_done[i] === 1'b1) done_cnt[i]++;
            if (err_timeout === 1'b1) err_cnt++;
        end
    end

    function automatic int pick(input logic [N-1:0] m, input int p);
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (p + k) % N;
            if (m[idx[1:0]]) return idx;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] onehot(input int g);
        logic [N-1:0] v;
        v = '0;
        v[g[1:0]] = 1'b1;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [7:0] d, input logic [1:0] s, input logic [1:0] p);
        bus.req_data[8*i +: 8]      = d;
        bus.req_stop_bits[2*i +: 2] = s;
        bus.req_parity[2*i +: 2]    = p;
        dat[i] = d;
        stp[i] = s;
        par[i] = p;
    endtask

    task automatic wait_start(input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            tick();
            if (bus.tx_start === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            tick();
            if (busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        exp_ptr = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.req = '0;
        tick();
        tick();
        total++;
        if ({busy, grant_id, err_timeout} !== 4'b0) begin
            bad++;
            $display("FAIL reset_status: got %h want 0", {busy, grant_id, err_timeout});
        end
        total++;
        if ({bus.tx_start, bus.req_ack, bus.req_done} !== 9'b0) begin
            bad++;
            $display("FAIL reset_pulses: got %h want 0", {bus.tx_start, bus.req_ack, bus.req_done});
        end
        total++;
        if ({bus.tx_data, bus.stop_bits, bus.parity} !== {8'h00, STOP_ONE, PARITY_NONE}) begin
            bad++;
            $display("FAIL reset_cfg: got %h want %h", {bus.tx_data, bus.stop_bits, bus.parity},
                     {8'h00, STOP_ONE, PARITY_NONE});
        end
        rst_n = 1'b1;
        exp_ptr = 0;
    endtask

    task automatic test_single();
        int d0[N];
        bit ok;
        m_en = 1'b1; m_start_dly = 2; m_frame_len = 10; m_stop2_len = 2;
        d0 = done_cnt;
        set_req(2, 8'hA5, STOP_TWO, PARITY_EVEN);
        bus.req = 4'b0100;
        tick();
        total++;
        if ({bus.tx_start, bus.req_ack, grant_id} !== {1'b1, 4'b0100, 2'd2}) begin
            bad++;
            $display("FAIL single_ack: got %h want %h", {bus.tx_start, bus.req_ack, grant_id}, {1'b1, 4'b0100, 2'd2});
        end
        total++;
        if ({bus.tx_data, bus.stop_bits, bus.parity} !== {8'hA5, STOP_TWO, PARITY_EVEN}) begin
            bad++;
            $display("FAIL single_cfg: got %h want %h", {bus.tx_data, bus.stop_bits, bus.parity},
                     {8'hA5, STOP_TWO, PARITY_EVEN});
        end
        bus.req = 4'b0000;
        tick();
        total++;
        if ({bus.tx_start, bus.req_ack} !== 5'b0) begin
            bad++;
            $display("FAIL single_pulse_width: got %h want 0", {bus.tx_start, bus.req_ack});
        end
        wait_idle(200, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL single_idle: got busy want idle"); end
        total++;
        if ({done_cnt[0]-d0[0], done_cnt[1]-d0[1], done_cnt[2]-d0[2], done_cnt[3]-d0[3]} !== {32'd0, 32'd0, 32'd1, 32'd0}) begin
            bad++;
            $display("FAIL single_done: got %0d %0d %0d %0d want 0 0 1 0", done_cnt[0]-d0[0],
                     done_cnt[1]-d0[1], done_cnt[2]-d0[2], done_cnt[3]-d0[3]);
        end
        exp_ptr = 3;
    endtask

    task automatic test_simultaneous();
        int d0[N];
        bit ok;
        int g;
        do_reset();
        m_en = 1'b1; m_start_dly = 1; m_frame_len = $urandom_range(4, 9); m_stop2_len = 1;
        for (int i = 0; i < N; i++) set_req(i, 8'($urandom), 2'($urandom_range(1, 2)), 2'($urandom_range(0, 2)));
        d0 = done_cnt;
        bus.req = 4'hF;
        for (int n = 0; n < 5; n++) begin
            wait_start(300, ok);
            total++;
            if (!ok) begin bad++; $display("FAIL simul_start%0d: got none want tx_start", n); break; end
            g = pick(4'hF, exp_ptr);
            total++;
            if ({grant_id, bus.req_ack, bus.tx_data} !== {2'(g), onehot(g), dat[g]}) begin
                bad++;
                $display("FAIL simul_grant%0d: got %h want %h", n, {grant_id, bus.req_ack, bus.tx_data},
                         {2'(g), onehot(g), dat[g]});
            end
            exp_ptr = (g + 1) % N;
            if (n == 4) bus.req = 4'h0;
            tick();
            total++;
            if (bus.tx_start !== 1'b0) begin bad++; $display("FAIL simul_overlap%0d: got 1 want 0", n); end
        end
        wait_idle(300, ok);
        total++;
        if ({done_cnt[0]-d0[0], done_cnt[1]-d0[1], done_cnt[2]-d0[2], done_cnt[3]-d0[3]} !== {32'd2, 32'd1, 32'd1, 32'd1}) begin
            bad++;
            $display("FAIL simul_done: got %0d %0d %0d %0d want 2 1 1 1", done_cnt[0]-d0[0],
                     done_cnt[1]-d0[1], done_cnt[2]-d0[2], done_cnt[3]-d0[3]);
        end
    endtask

    task automatic test_timeout();
        int d0[N];
        int e0, c, g, g2, dsum;
        bit ok, seen;
        d0 = done_cnt;
        e0 = err_cnt;
        m_en = 1'b0;
        bus.req = 4'hF;
        wait_start(50, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL timeout_start: got none want tx_start"); end
        g = pick(4'hF, exp_ptr);
        seen = 1'b0;
        c = 0;
        while (!seen && c < 40) begin
            tick();
            c++;
            if (err_timeout === 1'b1) seen = 1'b1;
        end
        total++;
        if (!seen || c != TO) begin bad++; $display("FAIL timeout_latency: got %0d seen=%0d want %0d", c, seen, TO); end
        m_en = 1'b1;
        exp_ptr = (g + 1) % N;
        g2 = pick(4'hF, exp_ptr);
        tick();
        total++;
        if ({err_timeout, bus.tx_start, grant_id} !== {1'b0, 1'b1, 2'(g2)}) begin
            bad++;
            $display("FAIL timeout_next_grant: got %h want %h", {err_timeout, bus.tx_start, grant_id}, {1'b0, 1'b1, 2'(g2)});
        end
        bus.req = 4'h0;
        exp_ptr = (g2 + 1) % N;
        wait_idle(300, ok);
        dsum = 0;
        for (int i = 0; i < N; i++) dsum += done_cnt[i] - d0[i];
        total++;
        if (done_cnt[g] != d0[g] || dsum != 1 || err_cnt - e0 != 1) begin
            bad++;
            $display("FAIL timeout_done: got lost=%0d dones=%0d errs=%0d want 0 1 1", done_cnt[g]-d0[g], dsum, err_cnt-e0);
        end
    endtask

    task automatic test_config_isolation();
        logic [7:0] x;
        logic [1:0] p, s;
        bit ok, seen;
        m_en = 1'b1; m_start_dly = 2; m_frame_len = 8; m_stop2_len = 0;
        x = 8'($urandom);
        p = 2'($urandom_range(0, 2));
        s = 2'($urandom_range(1, 2));
        set_req(1, x, s, p);
        bus.req = 4'b0010;
        wait_start(50, ok);
        total++;
        if ({ok, grant_id, bus.tx_data, bus.parity} !== {1'b1, 2'd1, x, p}) begin
            bad++;
            $display("FAIL iso_grant: got %h want %h", {ok, grant_id, bus.tx_data, bus.parity}, {1'b1, 2'd1, x, p});
        end
        exp_ptr = 2;
        tick();
        bus.req = 4'b0000;
        set_req(1, ~x, (s == STOP_TWO) ? STOP_ONE : STOP_TWO, 2'((p + 1) % 3));
        seen = 1'b0;
        for (int c = 0; c < 100; c++) begin
            tick();
            if (bus.req_done[1] === 1'b1) begin seen = 1'b1; break; end
        end
        total++;
        if ({seen, bus.tx_data, bus.stop_bits, bus.parity} !== {1'b1, x, s, p}) begin
            bad++;
            $display("FAIL iso_hold: got %h want %h", {seen, bus.tx_data, bus.stop_bits, bus.parity}, {1'b1, x, s, p});
        end
        wait_idle(100, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL iso_idle: got busy want idle"); end
    endtask

    task automatic test_back_to_back();
        int d3, fall_at, start_at;
        bit ok, seen_busy;
        m_en = 1'b1; m_start_dly = 1; m_frame_len = 6; m_stop2_len = 3;
        d3 = done_cnt[3];
        set_req(3, 8'($urandom), STOP_TWO, 2'($urandom_range(0, 2)));
        bus.req = 4'b1000;
        wait_start(50, ok);
        total++;
        if ({ok, grant_id, bus.stop_bits, bus.tx_data} !== {1'b1, 2'd3, STOP_TWO, dat[3]}) begin
            bad++;
            $display("FAIL b2b_first: got %h want %h", {ok, grant_id, bus.stop_bits, bus.tx_data}, {1'b1, 2'd3, STOP_TWO, dat[3]});
        end
        exp_ptr = 0;
        fall_at = -1;
        start_at = -1;
        seen_busy = 1'b0;
        for (int c = 1; c <= 200; c++) begin
            tick();
            if (bus.tx_busy === 1'b1) seen_busy = 1'b1;
            if (seen_busy && bus.tx_busy === 1'b0 && fall_at < 0) fall_at = c;
            if (bus.tx_start === 1'b1) begin start_at = c; break; end
        end
        total++;
        if (fall_at < 0 || start_at - fall_at != 1) begin
            bad++;
            $display("FAIL b2b_spacing: got fall=%0d start=%0d want start=fall+1", fall_at, start_at);
        end
        total++;
        if (grant_id !== 2'(pick(4'b1000, exp_ptr))) begin
            bad++;
            $display("FAIL b2b_regrant: got %0d want 3", grant_id);
        end
        bus.req = 4'b0000;
        exp_ptr = 0;
        wait_idle(200, ok);
        total++;
        if (!ok || done_cnt[3] - d3 != 2) begin
            bad++;
            $display("FAIL b2b_done: got %0d idle=%0d want 2", done_cnt[3] - d3, ok);
        end
    endtask

    task automatic test_reset_mid_frame();
        int d0[N];
        bit ok, seen;
        m_en = 1'b1; m_start_dly = 2; m_frame_len = 8; m_stop2_len = 0;
        set_req(2, 8'($urandom), STOP_TWO, PARITY_ODD);
        bus.req = 4'b0100;
        wait_start(50, ok);
        bus.req = 4'b0000;
        seen = 1'b0;
        for (int c = 0; c < 50; c++) begin
            tick();
            if (bus.tx_busy === 1'b1) begin seen = 1'b1; break; end
        end
        total++;
        if (!(ok && seen)) begin bad++; $display("FAIL rstmid_reach: got start=%0d busy=%0d want 1 1", ok, seen); end
        d0 = done_cnt;
        for (int i = 0; i < N; i++) set_req(i, 8'($urandom), STOP_ONE, PARITY_NONE);
        bus.req = 4'hF;
        rst_n = 1'b0;
        tick();
        total++;
        if ({busy, grant_id, err_timeout, bus.tx_start, bus.req_ack, bus.req_done, bus.tx_data, bus.stop_bits, bus.parity}
            !== {1'b0, 2'd0, 1'b0, 1'b0, 4'b0, 4'b0, 8'h00, STOP_ONE, PARITY_NONE}) begin
            bad++;
            $display("FAIL rstmid_outputs: got %h want %h",
                     {busy, grant_id, err_timeout, bus.tx_start, bus.req_ack, bus.req_done, bus.tx_data, bus.stop_bits, bus.parity},
                     {1'b0, 2'd0, 1'b0, 1'b0, 4'b0, 4'b0, 8'h00, STOP_ONE, PARITY_NONE});
        end
        tick();
        rst_n = 1'b1;
        exp_ptr = 0;
        wait_start(20, ok);
        total++;
        if ({ok, grant_id, bus.req_ack, bus.tx_data} !== {1'b1, 2'd0, 4'b0001, dat[0]}) begin
            bad++;
            $display("FAIL rstmid_first_grant: got %h want %h", {ok, grant_id, bus.req_ack, bus.tx_data}, {1'b1, 2'd0, 4'b0001, dat[0]});
        end
        bus.req = 4'h0;
        exp_ptr = 1;
        wait_idle(200, ok);
        total++;
        if (done_cnt[2] != d0[2] || done_cnt[0] - d0[0] != 1) begin
            bad++;
            $display("FAIL rstmid_done: got abandoned=%0d req0=%0d want 0 1", done_cnt[2]-d0[2], done_cnt[0]-d0[0]);
        end
    endtask

    task automatic test_random();
        int d0[N];
        int gcnt[N];
        logic [N-1:0] mask, nw;
        int g;
        bit ok;
        d0 = done_cnt;
        for (int i = 0; i < N; i++) gcnt[i] = 0;
        mask = '0;
        for (int r = 0; r < 60; r++) begin
            if (mask == '0) begin
                if (r >= 12) break;
                nw = 4'($urandom_range(1, 15));
                for (int i = 0; i < N; i++)
                    if (nw[i]) set_req(i, 8'($urandom), 2'($urandom), 2'($urandom_range(0, 2)));
                mask = nw;
            end
            m_start_dly = $urandom_range(1, 4);
            m_frame_len = $urandom_range(3, 8);
            m_stop2_len = $urandom_range(0, 2);
            bus.req = mask;
            wait_start(300, ok);
            g = pick(mask, exp_ptr);
            total++;
            if ({ok, grant_id, bus.req_ack, bus.tx_data, bus.stop_bits, bus.parity}
                !== {1'b1, 2'(g), onehot(g), dat[g], stp[g], par[g]}) begin
                bad++;
                $display("FAIL rand_grant%0d: got %h want %h", r,
                         {ok, grant_id, bus.req_ack, bus.tx_data, bus.stop_bits, bus.parity},
                         {1'b1, 2'(g), onehot(g), dat[g], stp[g], par[g]});
            end
            mask[g[1:0]] = 1'b0;
            bus.req = mask;
            exp_ptr = (g + 1) % N;
            gcnt[g]++;
        end
        wait_idle(300, ok);
        for (int i = 0; i < N; i++) begin
            total++;
            if (done_cnt[i] - d0[i] != gcnt[i]) begin
                bad++;
                $display("FAIL rand_done%0d: got %0d want %0d", i, done_cnt[i] - d0[i], gcnt[i]);
            end
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        exp_ptr = 0;
        rst_n = 1'b0;
        bus.req = '0;
        bus.req_data = '0;
        bus.req_stop_bits = {N{STOP_ONE}};
        bus.req_parity = '0;
        m_en = 1'b1;
        m_start_dly = 2;
        m_frame_len = 6;
        m_stop2_len = 0;
        test_reset();
        test_single();
        test_simultaneous();
        test_timeout();
        test_config_isolation();
        test_back_to_back();
        test_reset_mid_frame();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
